// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-edge frame and ack.
// Build option PS2_TX_ACK_CHECK_EN: a high data line at the ack edge pulses tx_err instead of tx_done.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       key_clk_oe,
  output logic       key_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK
  } state_t;

  state_t           state_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       edge_cnt_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             done_q;
  logic             err_q;
  logic             clk_s1_q;
  logic             clk_s2_q;
  logic             clk_prev_q;
  logic             data_s1_q;
  logic             data_s2_q;

  logic             edge_fall;
  logic [9:0]       frame_bits;

  assign edge_fall  = clk_prev_q & ~clk_s2_q;
  // Bit presented after edge n is frame_bits[n-1]: data LSB first, parity, stop.
  assign frame_bits = {1'b1, parity_q, data_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= key_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= key_data;
      data_s2_q  <= data_s1_q;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            data_q     <= tx_data;
            parity_q   <= ~^tx_data;
            edge_cnt_q <= '0;
            inh_cnt_q  <= INH_W'(INHIBIT_CYCLES - 1);
            clk_oe_q   <= 1'b1;
            data_oe_q  <= (INHIBIT_CYCLES == 1);
            state_q    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt_q == INH_W'(1)) begin
            data_oe_q <= 1'b1;
          end
          if (inh_cnt_q == '0) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= S_REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q - INH_W'(1);
          end
        end

        S_REQ, S_SHIFT: begin
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (edge_fall) begin
              edge_cnt_q <= edge_cnt_q + 4'd1;
              if (edge_cnt_q == 4'd10) begin
                data_oe_q <= 1'b0;
                state_q   <= S_ACK;
              end else begin
                data_oe_q <= ~frame_bits[edge_cnt_q];
                state_q   <= S_SHIFT;
              end
            end
          end
        end

        S_ACK: begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (data_s2_q) begin
            err_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
`else
          done_q <= 1'b1;
`endif
          to_cnt_q <= '0;
          state_q  <= S_IDLE;
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

`ifndef PS2_TX_ACK_CHECK_EN
  // The ack level only matters when it is checked.
  logic unused_ack;
  assign unused_ack = data_s2_q;
`endif

  assign tx_ready    = (state_q == S_IDLE);
  assign key_clk_oe  = clk_oe_q;
  assign key_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, behavioural PS/2 device and frame reference model.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 3000;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       key_clk;
  logic       key_data;
  logic       tx_ready;
  logic       key_clk_oe;
  logic       key_data_oe;
  logic       tx_done;
  logic       tx_err;

  // Open-drain bus: low if either side pulls.
  assign key_clk  = dev_clk & ~key_clk_oe;
  assign key_data = dev_data & ~key_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .key_clk    (key_clk),
    .key_data   (key_data),
    .key_clk_oe (key_clk_oe),
    .key_data_oe(key_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  int n_checks = 0;
  int n_fail = 0;
  int half = 8;

  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int inh_runs = 0;
  int run_len = 0;
  int run_data = 0;
  int last_inh = 0;
  int last_inh_data = 0;
  int req_cyc = 0;
  int err_cyc = 0;
  int inh_runs_at_done = 0;
  bit clk_oe_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      inh_runs_at_done = inh_runs;
    end
    if (tx_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (tx_done === 1'b1 && tx_err === 1'b1) overlap_cnt = overlap_cnt + 1;
    if (key_clk_oe === 1'b1) begin
      if (!clk_oe_prev) inh_runs = inh_runs + 1;
      run_len = run_len + 1;
      if (key_data_oe === 1'b1) run_data = run_data + 1;
      clk_oe_prev = 1'b1;
    end else begin
      if (clk_oe_prev) begin
        last_inh      = run_len;
        last_inh_data = run_data;
        req_cyc       = cyc;
      end
      run_len     = 0;
      run_data    = 0;
      clk_oe_prev = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire order on the bus: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic device_frame(input int n_edges, input bit ack_low, output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (key_clk_oe !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (key_clk_oe !== 1'b1) begin
      check("dev_wait_inhibit", {63'd0, key_clk_oe}, 64'd1);
      return;
    end
    w = 0;
    while (key_clk_oe !== 1'b0 && w < INH + 200) begin
      tick();
      w++;
    end
    if (key_clk_oe !== 1'b0) begin
      check("dev_wait_request", {63'd0, key_clk_oe}, 64'd0);
      return;
    end
    repeat (half) tick();
    for (int e = 1; e <= n_edges; e++) begin
      bits[e-1] = key_data;
      if (e == 11 && ack_low) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (half) tick();
      dev_clk = 1'b1;
      repeat (half) tick();
    end
    dev_data = 1'b1;
  endtask

  task automatic run_vec(input string name, input logic [7:0] d, input bit ack_low,
                         input bit exp_done, input bit exp_err);
    logic [10:0] bits;
    int d0;
    int e0;
    check({name, "_ready_before"}, {63'd0, tx_ready}, 64'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    device_frame(11, ack_low, bits);
    repeat (4) tick();
    check({name, "_bits"}, 64'(bits), 64'(frame_model(d)));
    check({name, "_inhibit_len"}, 64'(last_inh), 64'(INH));
    check({name, "_data_oe_last_inhibit"}, 64'(last_inh_data), 64'd1);
    check({name, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
    check({name, "_err"}, 64'(err_cnt - e0), 64'(exp_err));
    check({name, "_ready_after"}, {63'd0, tx_ready}, 64'd1);
    check({name, "_released"}, {62'd0, key_clk_oe, key_data_oe}, 64'd0);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       ack_low;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [10:0] bits;
    logic [10:0] ref_bits;
    int d0;
    int e0;
    int base_runs;
    int w;
    bit ack_low;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, !ACK_CHK, ACK_CHK};
    vecs[5] = '{8'hA5, 1'b0, !ACK_CHK, ACK_CHK};

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_ready", {63'd0, tx_ready}, 64'd1);
    check("reset_clk_oe", {63'd0, key_clk_oe}, 64'd0);
    check("reset_data_oe", {63'd0, key_data_oe}, 64'd0);
    check("reset_pulses", {62'd0, tx_done, tx_err}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack_low,
              vecs[i].exp_done, vecs[i].exp_err);
    end

    for (int i = 0; i < 8; i++) begin
      half    = int'($urandom_range(4, 12));
      ack_low = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", i), 8'($urandom_range(0, 255)), ack_low,
              ack_low | !ACK_CHK, !ack_low & ACK_CHK);
    end
    half = 8;

    // Device goes silent after six edges.
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device_frame(6, 1'b1, bits);
    ref_bits = frame_model(8'h96);
    check("timeout_partial_bits", 64'(bits[5:0]), 64'(ref_bits[5:0]));
    w = 0;
    while (err_cnt == e0 && w < TO + 100) begin
      tick();
      w++;
    end
    check("timeout_fired", 64'(err_cnt - e0), 64'd1);
    check("timeout_latency", 64'(err_cyc - req_cyc), 64'(TO));
    check("timeout_released", {62'd0, key_clk_oe, key_data_oe}, 64'd0);
    check("timeout_ready", {63'd0, tx_ready}, 64'd1);
    check("timeout_no_done", 64'(done_cnt - d0), 64'd0);
    run_vec("after_timeout", 8'h3A, 1'b1, 1'b1, 1'b0);

    // One-cycle reset in the middle of the data bits.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device_frame(4, 1'b1, bits);
    d0 = done_cnt;
    e0 = err_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_ready", {63'd0, tx_ready}, 64'd1);
    check("midreset_released", {62'd0, key_clk_oe, key_data_oe}, 64'd0);
    repeat (50) tick();
    check("midreset_no_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
    check("midreset_still_idle", {63'd0, tx_ready}, 64'd1);
    run_vec("after_reset", 8'h5A, 1'b1, 1'b1, 1'b0);

    // tx_valid held across a whole frame.
    base_runs = inh_runs;
    d0 = done_cnt;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    device_frame(11, 1'b1, bits);
    check("held_one_frame_at_done", 64'(inh_runs_at_done - base_runs), 64'd1);
    check("held_first_bits", 64'(bits), 64'(frame_model(8'h3C)));
    tx_valid = 1'b0;
    device_frame(11, 1'b1, bits);
    repeat (4) tick();
    check("held_second_bits", 64'(bits), 64'(frame_model(8'h3C)));
    check("held_frames", 64'(inh_runs - base_runs), 64'd2);
    check("held_done", 64'(done_cnt - d0), 64'd2);
    check("held_ready", {63'd0, tx_ready}, 64'd1);

    check("done_err_overlap", 64'(overlap_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
